// File: rtl/adder_seq_pkg.sv
// Shared types and default constants for the adder sweep sequencer.
// The state encoding is used by the top-level FSM.
package adder_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOAD,
      RUN,
      STOP,
      EMIT,
      DONE
   } seq_state_t;

   localparam int DEF_N_BITS         = 8;
   localparam int DEF_COUNT_W        = 32;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_TIMEOUT_MARGIN = 16;

endpackage

// File: rtl/onehot_b_decode.sv
// Index to active-low one-hot decoder for the adder bit-select buses.
// Out-of-range indices leave every line deasserted (all ones).
module onehot_b_decode #(
   parameter int N_BITS = 8,
   parameter int IDX_W  = 3
) (
   input  logic [IDX_W-1:0]  idx,
   output logic [N_BITS-1:0] onehot_b
);

   always_comb begin
      onehot_b = '1;
      for (int i = 0; i < N_BITS; i++) begin
         if (idx == IDX_W'(i)) begin
            onehot_b[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/adder_sweep_sequencer.sv
// Sweeps the instrumented adder's sum-output bit for a fixed ring input bit,
// running one timed integration per bit and returning one record per bit.
module adder_sweep_sequencer
   import adder_seq_pkg::*;
#(
   parameter int N_BITS         = DEF_N_BITS,
   parameter int COUNT_W        = DEF_COUNT_W,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_MARGIN = DEF_TIMEOUT_MARGIN
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic [$clog2(N_BITS)-1:0]  in_bit,
   input  logic [$clog2(N_BITS)-1:0]  out_first,
   input  logic [$clog2(N_BITS)-1:0]  out_last,
   input  logic [COUNT_W-1:0]         integration_time,
   input  logic                       extra_inverter,
   input  logic                       adder_done,
   input  logic [COUNT_W-1:0]         adder_count,
   output logic                       adder_reset,
   output logic                       adder_stop_b,
   output logic                       adder_bypass_b,
   output logic                       adder_control_b,
   output logic                       adder_counter_enable,
   output logic                       adder_counter_load,
   output logic [COUNT_W-1:0]         adder_integration_time,
   output logic [N_BITS-1:0]          adder_a_ring_bit_b,
   output logic [N_BITS-1:0]          adder_s_out_bit_b,
   output logic                       adder_extra_inverter,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [$clog2(N_BITS)-1:0]  res_bit,
   output logic [COUNT_W-1:0]         res_count,
   output logic                       res_timeout,
   output logic                       busy,
   output logic                       sweep_done,
   output logic                       cfg_err
);

   localparam int SEL_W       = $clog2(N_BITS);
   localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
   localparam int SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [SETTLE_W-1:0] SETTLE_LAST_V = SETTLE_W'(SETTLE_LAST);
   localparam logic [SETTLE_W-1:0] SETTLE_ONE    = SETTLE_W'(1);
   localparam logic [COUNT_W:0]    WD_ONE        = (COUNT_W+1)'(1);
   localparam logic [COUNT_W:0]    WD_MARGIN     = (COUNT_W+1)'(TIMEOUT_MARGIN);
   localparam logic [SEL_W-1:0]    SEL_ONE       = SEL_W'(1);

   seq_state_t state;
   seq_state_t state_next;

   logic [SEL_W-1:0]    ring_bit;
   logic [SEL_W-1:0]    cur_bit;
   logic [SEL_W-1:0]    last_bit;
   logic [COUNT_W:0]    watchdog;
   logic [COUNT_W:0]    wd_limit;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                run_timeout;

   logic                cfg_ok;
   logic                wd_expired;
   logic                settle_last;
   logic                sweep_last;
   logic [N_BITS-1:0]   a_dec_b;
   logic [N_BITS-1:0]   s_dec_b;

   // The limit is one bit wider than the counter so a large integration time cannot wrap it.
   assign cfg_ok      = (out_first <= out_last);
   assign wd_limit    = {1'b0, adder_integration_time} + WD_MARGIN;
   assign wd_expired  = ((watchdog + WD_ONE) >= wd_limit);
   assign settle_last = (settle_cnt == SETTLE_LAST_V);
   assign sweep_last  = (cur_bit == last_bit) || abort;

   assign adder_bypass_b       = 1'b1;
   assign adder_control_b      = 1'b1;
   assign adder_extra_inverter = extra_inverter;
   assign busy                 = (state != IDLE);

   onehot_b_decode #(
      .N_BITS (N_BITS),
      .IDX_W  (SEL_W)
   ) u_ring_dec (
      .idx      (ring_bit),
      .onehot_b (a_dec_b)
   );

   onehot_b_decode #(
      .N_BITS (N_BITS),
      .IDX_W  (SEL_W)
   ) u_sum_dec (
      .idx      (cur_bit),
      .onehot_b (s_dec_b)
   );

   // Selects stay released while idle so the adder sees no stale bit choice.
   assign adder_a_ring_bit_b = (state == IDLE) ? '1 : a_dec_b;
   assign adder_s_out_bit_b  = (state == IDLE) ? '1 : s_dec_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next           = state;
      adder_reset          = 1'b0;
      adder_stop_b         = 1'b0;
      adder_counter_enable = 1'b0;
      adder_counter_load   = 1'b0;
      res_valid            = 1'b0;
      sweep_done           = 1'b0;
      case (state)
         IDLE: begin
            adder_reset = 1'b1;
            if (start && cfg_ok) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            adder_reset = 1'b1;
            state_next  = abort ? DONE : LOAD;
         end
         LOAD: begin
            adder_counter_load = 1'b1;
            state_next         = abort ? DONE : RUN;
         end
         RUN: begin
            adder_stop_b         = 1'b1;
            adder_counter_enable = 1'b1;
            if (adder_done || wd_expired) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (settle_last) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = sweep_last ? DONE : SETUP;
            end
         end
         DONE: begin
            adder_reset = 1'b1;
            sweep_done  = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sweep configuration, watchdog, settle timer and the result record.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ring_bit               <= '0;
         cur_bit                <= '0;
         last_bit               <= '0;
         adder_integration_time <= '0;
         watchdog               <= '0;
         settle_cnt             <= '0;
         run_timeout            <= 1'b0;
         res_bit                <= '0;
         res_count              <= '0;
         res_timeout            <= 1'b0;
         cfg_err                <= 1'b0;
      end else begin
         cfg_err <= (state == IDLE) && start && !cfg_ok;
         case (state)
            IDLE: begin
               if (start && cfg_ok) begin
                  ring_bit               <= in_bit;
                  cur_bit                <= out_first;
                  last_bit               <= out_last;
                  adder_integration_time <= integration_time;
               end
            end
            LOAD: begin
               watchdog    <= '0;
               run_timeout <= 1'b0;
            end
            RUN: begin
               watchdog   <= watchdog + WD_ONE;
               settle_cnt <= '0;
               if (adder_done) begin
                  run_timeout <= 1'b0;
               end else if (wd_expired) begin
                  run_timeout <= 1'b1;
               end
            end
            STOP: begin
               settle_cnt <= settle_cnt + SETTLE_ONE;
               // The ring counter is asynchronous; it is only trusted once the settle time has elapsed.
               if (settle_last) begin
                  res_bit     <= cur_bit;
                  res_count   <= adder_count;
                  res_timeout <= run_timeout;
               end
            end
            EMIT: begin
               if (res_ready && !sweep_last) begin
                  cur_bit <= cur_bit + SEL_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_sweep_sequencer.sv
// Scoreboard bench for adder_sweep_sequencer with a behavioural adder model.
// Stimulus pushes hand-computed records; a negedge monitor pops and compares.
module tb_adder_sweep_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        abort;
   logic [2:0]  in_bit;
   logic [2:0]  out_first;
   logic [2:0]  out_last;
   logic [31:0] integration_time;
   logic        extra_inverter;
   logic        adder_done;
   logic [31:0] adder_count;
   logic        adder_reset;
   logic        adder_stop_b;
   logic        adder_bypass_b;
   logic        adder_control_b;
   logic        adder_counter_enable;
   logic        adder_counter_load;
   logic [31:0] adder_integration_time;
   logic [7:0]  adder_a_ring_bit_b;
   logic [7:0]  adder_s_out_bit_b;
   logic        adder_extra_inverter;
   logic        res_valid;
   logic        res_ready;
   logic [2:0]  res_bit;
   logic [31:0] res_count;
   logic        res_timeout;
   logic        busy;
   logic        sweep_done;
   logic        cfg_err;

   typedef struct {
      logic [2:0]  bit_idx;
      logic [31:0] count;
      logic        timeout;
      int          run_len;
   } exp_rec_t;

   exp_rec_t    exp_q[$];
   int          check_count = 0;
   int          pass_count  = 0;
   int          rec_seen    = 0;
   int          cfg_err_seen = 0;
   int          sweep_done_seen = 0;
   int          busy_cycles = 0;
   int          last_run_len = 0;
   logic [31:0] count_tab [8];
   logic        done_enable;

   adder_sweep_sequencer dut (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (start),
      .abort                  (abort),
      .in_bit                 (in_bit),
      .out_first              (out_first),
      .out_last               (out_last),
      .integration_time       (integration_time),
      .extra_inverter         (extra_inverter),
      .adder_done             (adder_done),
      .adder_count            (adder_count),
      .adder_reset            (adder_reset),
      .adder_stop_b           (adder_stop_b),
      .adder_bypass_b         (adder_bypass_b),
      .adder_control_b        (adder_control_b),
      .adder_counter_enable   (adder_counter_enable),
      .adder_counter_load     (adder_counter_load),
      .adder_integration_time (adder_integration_time),
      .adder_a_ring_bit_b     (adder_a_ring_bit_b),
      .adder_s_out_bit_b      (adder_s_out_bit_b),
      .adder_extra_inverter   (adder_extra_inverter),
      .res_valid              (res_valid),
      .res_ready              (res_ready),
      .res_bit                (res_bit),
      .res_count              (res_count),
      .res_timeout            (res_timeout),
      .busy                   (busy),
      .sweep_done             (sweep_done),
      .cfg_err                (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int selIdx(input logic [7:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) begin
         if (!v[i]) r = i;
      end
      return r;
   endfunction

   // Adder model: integration counter raises done after integration_time enabled cycles.
   logic [31:0] icnt;
   logic        done_q;
   always @(posedge clk) begin
      if (adder_reset || adder_counter_load) begin
         icnt   <= 32'd0;
         done_q <= 1'b0;
      end else if (adder_counter_enable && done_enable) begin
         icnt <= icnt + 32'd1;
         if (icnt + 32'd1 >= adder_integration_time) done_q <= 1'b1;
      end
   end
   assign adder_done = done_q;

   // Ring counter model: garbage while running, final value only after two stopped cycles.
   logic [31:0] ring_cnt;
   logic [1:0]  ring_settle;
   always @(posedge clk) begin
      if (adder_reset) begin
         ring_cnt    <= 32'd0;
         ring_settle <= 2'd0;
      end else if (adder_stop_b) begin
         ring_cnt    <= ring_cnt + 32'd7;
         ring_settle <= 2'd0;
      end else if (ring_settle < 2'd2) begin
         ring_cnt    <= ring_cnt + 32'd3;
         ring_settle <= ring_settle + 2'd1;
      end else begin
         ring_cnt <= count_tab[selIdx(adder_s_out_bit_b)];
      end
   end
   assign adder_count = ring_cnt;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input logic [2:0] b, input logic [31:0] c, input logic t, input int rl);
      exp_rec_t e;
      e.bit_idx = b;
      e.count   = c;
      e.timeout = t;
      e.run_len = rl;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic [2:0] ring, input logic [2:0] first,
                                input logic [2:0] last, input logic [31:0] itime);
      @(posedge clk);
      #1;
      in_bit           = ring;
      out_first        = first;
      out_last         = last;
      integration_time = itime;
      start            = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitSweepDone(input string name, input int max_cycles);
      int base;
      int n;
      base = sweep_done_seen;
      n    = 0;
      while (sweep_done_seen == base && n < max_cycles) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput({name, "_sweep_done_once"}, 64'(sweep_done_seen - base), 64'd1);
      checkOutput({name, "_busy_after"}, {63'd0, busy}, 64'd0);
      checkOutput({name, "_records_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: pops the scoreboard on every transfer and checks holding under backpressure.
   initial begin : monitor
      exp_rec_t    e;
      logic        stall;
      logic [35:0] held;
      int          run_cnt;
      stall   = 1'b0;
      held    = '0;
      run_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall   = 1'b0;
            run_cnt = 0;
         end else begin
            if (adder_stop_b) begin
               run_cnt++;
            end else if (run_cnt != 0) begin
               last_run_len = run_cnt;
               run_cnt      = 0;
            end
            if (cfg_err) cfg_err_seen++;
            if (sweep_done) sweep_done_seen++;
            if (busy) busy_cycles++;
            if (res_valid) begin
               if (stall) begin
                  checkOutput("hold_stable", {28'd0, res_bit, res_count, res_timeout}, {28'd0, held});
                  checkOutput("stopped_in_stall", {63'd0, adder_stop_b}, 64'd0);
               end
               if (res_ready) begin
                  stall = 1'b0;
                  rec_seen++;
                  if (exp_q.size() == 0) begin
                     check_count++;
                     $display("[TB] FAIL unexpected_record: got bit %0d count %0h, required no record",
                              res_bit, res_count);
                  end else begin
                     e = exp_q.pop_front();
                     checkOutput("rec_bit", {61'd0, res_bit}, {61'd0, e.bit_idx});
                     checkOutput("rec_count", {32'd0, res_count}, {32'd0, e.count});
                     checkOutput("rec_timeout", {63'd0, res_timeout}, {63'd0, e.timeout});
                     if (e.run_len != 0) checkOutput("rec_run_len", 64'(last_run_len), 64'(e.run_len));
                  end
               end else begin
                  stall = 1'b1;
                  held  = {res_bit, res_count, res_timeout};
               end
            end else begin
               stall = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog_guard
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "[TB] global timeout");
   end

   initial begin : stimulus
      int base_rec;
      int base_cfg;
      int base_done;
      int base_busy;
      int n;

      reset            = 1'b1;
      start            = 1'b0;
      abort            = 1'b0;
      in_bit           = 3'd0;
      out_first        = 3'd0;
      out_last         = 3'd0;
      integration_time = 32'd0;
      extra_inverter   = 1'b1;
      res_ready        = 1'b1;
      done_enable      = 1'b1;
      for (int i = 0; i < 8; i++) count_tab[i] = 32'd0;

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_adder_reset", {63'd0, adder_reset}, 64'd1);
      checkOutput("rst_stop_b", {63'd0, adder_stop_b}, 64'd0);
      checkOutput("rst_enable", {63'd0, adder_counter_enable}, 64'd0);
      checkOutput("rst_load", {63'd0, adder_counter_load}, 64'd0);
      checkOutput("rst_a_bit_b", {56'd0, adder_a_ring_bit_b}, 64'hFF);
      checkOutput("rst_s_bit_b", {56'd0, adder_s_out_bit_b}, 64'hFF);
      checkOutput("rst_res_valid", {63'd0, res_valid}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_bypass_b", {63'd0, adder_bypass_b}, 64'd1);
      checkOutput("rst_control_b", {63'd0, adder_control_b}, 64'd1);
      checkOutput("extra_inv_pass", {63'd0, adder_extra_inverter}, 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic sweep: bits 0..2, done after 100 cycles, observed one cycle later.
      $display("[TB] basic sweep");
      count_tab[0] = 32'd50;
      count_tab[1] = 32'd40;
      count_tab[2] = 32'd30;
      pushExp(3'd0, 32'd50, 1'b0, 101);
      pushExp(3'd1, 32'd40, 1'b0, 101);
      pushExp(3'd2, 32'd30, 1'b0, 101);
      applyStimulus(3'd0, 3'd0, 3'd2, 32'd100);
      waitSweepDone("basic", 2000);

      // Backpressure on the first record of a two-bit sweep.
      $display("[TB] backpressure");
      count_tab[4] = 32'd11;
      count_tab[5] = 32'd22;
      pushExp(3'd4, 32'd11, 1'b0, 21);
      pushExp(3'd5, 32'd22, 1'b0, 21);
      res_ready = 1'b0;
      applyStimulus(3'd1, 3'd4, 3'd5, 32'd20);
      n = 0;
      while (!res_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("bp_first_valid", {63'd0, res_valid}, 64'd1);
      repeat (20) @(posedge clk);
      #1;
      res_ready = 1'b1;
      waitSweepDone("backpressure", 500);

      // Timeout: done never rises, limit 10 + 16 = 26 RUN cycles.
      $display("[TB] timeout");
      done_enable  = 1'b0;
      count_tab[3] = 32'd123;
      count_tab[4] = 32'd77;
      pushExp(3'd3, 32'd123, 1'b1, 26);
      pushExp(3'd4, 32'd77, 1'b1, 26);
      applyStimulus(3'd2, 3'd3, 3'd4, 32'd10);
      waitSweepDone("timeout", 500);
      done_enable = 1'b1;

      // Config error: first > last.
      $display("[TB] config error");
      base_rec  = rec_seen;
      base_cfg  = cfg_err_seen;
      base_done = sweep_done_seen;
      base_busy = busy_cycles;
      applyStimulus(3'd0, 3'd5, 3'd3, 32'd10);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("cfg_err_pulses", 64'(cfg_err_seen - base_cfg), 64'd1);
      checkOutput("cfg_busy_cycles", 64'(busy_cycles - base_busy), 64'd0);
      checkOutput("cfg_sweep_done", 64'(sweep_done_seen - base_done), 64'd0);
      checkOutput("cfg_records", 64'(rec_seen - base_rec), 64'd0);

      // Abort during the bit-1 run of a 0..7 sweep.
      $display("[TB] abort");
      count_tab[0] = 32'd50;
      count_tab[1] = 32'd40;
      count_tab[2] = 32'd30;
      pushExp(3'd0, 32'd50, 1'b0, 21);
      pushExp(3'd1, 32'd40, 1'b0, 21);
      base_rec = rec_seen;
      applyStimulus(3'd2, 3'd0, 3'd7, 32'd20);
      n = 0;
      while (!((rec_seen - base_rec) >= 1 && adder_stop_b) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("abort_in_run", {63'd0, adder_stop_b}, 64'd1);
      checkOutput("abort_a_bit_b", {56'd0, adder_a_ring_bit_b}, 64'hFB);
      checkOutput("abort_s_bit_b", {56'd0, adder_s_out_bit_b}, 64'hFD);
      checkOutput("abort_itime", {32'd0, adder_integration_time}, 64'd20);
      @(posedge clk);
      #1;
      abort = 1'b1;
      waitSweepDone("abort", 500);
      abort = 1'b0;
      checkOutput("abort_records", 64'(rec_seen - base_rec), 64'd2);

      // Asynchronous reset while the ring is stopped and settling.
      $display("[TB] async reset");
      applyStimulus(3'd0, 3'd0, 3'd2, 32'd20);
      n = 0;
      while (!(busy && !adder_reset && !adder_counter_load && !adder_stop_b && !res_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("ar_reached_stop", {63'd0, busy && !adder_counter_load && !adder_stop_b}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("ar_adder_reset", {63'd0, adder_reset}, 64'd1);
      checkOutput("ar_stop_b", {63'd0, adder_stop_b}, 64'd0);
      checkOutput("ar_enable", {63'd0, adder_counter_enable}, 64'd0);
      checkOutput("ar_s_bit_b", {56'd0, adder_s_out_bit_b}, 64'hFF);
      checkOutput("ar_a_bit_b", {56'd0, adder_a_ring_bit_b}, 64'hFF);
      checkOutput("ar_res_valid", {63'd0, res_valid}, 64'd0);
      checkOutput("ar_res_count", {32'd0, res_count}, 64'd0);
      checkOutput("ar_res_bit", {61'd0, res_bit}, 64'd0);
      checkOutput("ar_busy", {63'd0, busy}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      pushExp(3'd0, 32'd50, 1'b0, 21);
      pushExp(3'd1, 32'd40, 1'b0, 21);
      pushExp(3'd2, 32'd30, 1'b0, 21);
      applyStimulus(3'd0, 3'd0, 3'd2, 32'd20);
      waitSweepDone("after_reset", 500);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
